// File: rtl/codec_cfg_seq.sv
// Audio codec register-init sequencer: replays a fixed 11-entry table through an I2C write engine.
// Optional user-write port enabled by defining CODEC_CFG_USER_EN.
module codec_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter logic [15:0] STARTUP_CYCLES = 16'd50000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd16,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_idle,
  output logic        wr_i2c,
  output logic [23:0] din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  idx
`ifdef CODEC_CFG_USER_EN
  ,
  input  logic        usr_req,
  input  logic [6:0]  usr_addr,
  input  logic [8:0]  usr_data,
  output logic        usr_ack
`endif
);

  typedef enum logic [2:0] {
    S_START, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE, S_GAP, S_DONE
  } state_t;

  localparam logic [3:0]  LAST_IDX     = 4'd10;
  localparam logic [15:0] NOFALL_LIMIT = 16'd3;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [3:0]  r_idx;
  logic        r_done;
  logic        r_err;
  logic [15:0] w_tbl_word;
  logic [15:0] w_word_lo;
  logic        w_usr_mode;
  logic        w_usr_go;
  logic        w_wr_complete;
  logic        w_timeout;
  logic        w_gap_end;

  // A write completes when the engine returns idle, or if it never left idle after the strobe.
  assign w_wr_complete = ((r_state == S_WAIT_BUSY) && i2c_idle && (r_cnt == NOFALL_LIMIT)) ||
                         ((r_state == S_WAIT_IDLE) && i2c_idle);
  assign w_timeout     = (r_state == S_WAIT_IDLE) && !i2c_idle &&
                         (r_cnt == TIMEOUT_CYCLES - 16'd1);
  assign w_gap_end     = (r_state == S_GAP) && (r_cnt == {8'd0, GAP_CYCLES} - 16'd1);

  always_comb begin
    case (r_idx)
      4'd0:    w_tbl_word = {7'h0F, 9'h000};
      4'd1:    w_tbl_word = {7'h00, 9'h017};
      4'd2:    w_tbl_word = {7'h01, 9'h017};
      4'd3:    w_tbl_word = {7'h02, 9'h079};
      4'd4:    w_tbl_word = {7'h03, 9'h079};
      4'd5:    w_tbl_word = {7'h04, 9'h012};
      4'd6:    w_tbl_word = {7'h05, 9'h000};
      4'd7:    w_tbl_word = {7'h06, 9'h000};
      4'd8:    w_tbl_word = {7'h07, 9'h042};
      4'd9:    w_tbl_word = {7'h08, 9'h000};
      4'd10:   w_tbl_word = {7'h09, 9'h001};
      default: w_tbl_word = 16'h0000;
    endcase
  end

`ifdef CODEC_CFG_USER_EN
  logic        r_usr_mode;
  logic [15:0] r_usr_word;
  logic        r_usr_ack;

  // start wins over a pending user request when both are seen in S_DONE.
  assign w_usr_go   = usr_req && !start;
  assign w_usr_mode = r_usr_mode;
  assign w_word_lo  = r_usr_mode ? r_usr_word : w_tbl_word;
  assign usr_ack    = r_usr_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_usr_mode <= 1'b0;
      r_usr_word <= 16'h0000;
      r_usr_ack  <= 1'b0;
    end else begin
      r_usr_ack <= 1'b0;
      if ((r_state == S_DONE) && w_usr_go) begin
        r_usr_mode <= 1'b1;
        r_usr_word <= {usr_addr, usr_data};
      end
      if (r_usr_mode && w_wr_complete) begin
        r_usr_mode <= 1'b0;
        r_usr_ack  <= 1'b1;
      end
      if (r_usr_mode && w_timeout) begin
        r_usr_mode <= 1'b0;
      end
    end
  end
`else
  assign w_usr_go   = 1'b0;
  assign w_usr_mode = 1'b0;
  assign w_word_lo  = w_tbl_word;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: default assignment first, so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:     if (r_cnt == STARTUP_CYCLES - 16'd1) w_next = S_ISSUE;
      S_ISSUE:     if (i2c_idle) w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i2c_idle)          w_next = S_WAIT_IDLE;
        else if (w_wr_complete) w_next = w_usr_mode ? S_DONE : S_GAP;
      end
      S_WAIT_IDLE: begin
        if (w_wr_complete)  w_next = w_usr_mode ? S_DONE : S_GAP;
        else if (w_timeout) w_next = S_DONE;
      end
      S_GAP:       if (w_gap_end) w_next = (r_idx < LAST_IDX) ? S_ISSUE : S_DONE;
      S_DONE:      if (start || w_usr_go) w_next = S_ISSUE;
      default:     w_next = S_START;
    endcase
  end

  always_comb begin
    wr_i2c = 1'b0;
    din    = 24'h000000;
    busy   = (r_state != S_DONE);
    if (r_state == S_ISSUE) wr_i2c = i2c_idle;
    if ((r_state == S_ISSUE) || (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_IDLE))
      din = {DEV_ADDR, w_word_lo};
  end

  assign done = r_done;
  assign err  = r_err;
  assign idx  = r_idx;

  // One shared counter, cleared on every state change, times each state's dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 16'd0;
      r_idx  <= 4'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (w_gap_end && (r_idx < LAST_IDX)) r_idx <= r_idx + 4'd1;
      if (w_gap_end && (r_idx == LAST_IDX)) r_done <= 1'b1;
      if (w_timeout) begin
        r_err  <= 1'b1;
        r_done <= 1'b1;
      end
      if ((r_state == S_DONE) && start) begin
        r_idx  <= 4'd0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'h34: I2C write address byte placed in din[23:16].
REQ-002 Parameter STARTUP_CYCLES, default 16'd50000: delay after reset before the first write.
REQ-003 Parameter GAP_CYCLES, default 8'd16: idle gap between consecutive writes.
REQ-004 Parameter TIMEOUT_CYCLES, default 16'd4000: maximum wait for the I2C engine to return idle.
REQ-005 Port clk  input  1  clock; all logic on the rising edge.
REQ-006 Port reset  input  1  reset; synchronous, active-high.
REQ-007 Port start  input  1  single-cycle request to re-run the full init table.
REQ-008 Port i2c_idle  input  1  I2C engine idle flag; high means ready or finished.
REQ-009 Port wr_i2c  output  1  single-cycle write strobe to the I2C engine.
REQ-010 Port din  output  24  write word {DEV_ADDR, reg[6:0], data[8:0]}.
REQ-011 Port busy  output  1  high while the sequencer owns the engine.
REQ-012 Port done  output  1  high once the init table has completed.
REQ-013 Port err  output  1  sticky flag; high after a timeout.
REQ-014 Port idx  output  4  index of the current table entry.

Function
REQ-015 The fixed table SHALL be, as index:reg/data: 0:0F/000, 1:00/017, 2:01/017, 3:02/079, 4:03/079, 5:04/012, 6:05/000, 7:06/000, 8:07/042, 9:08/000, 10:09/001 (11 entries).
REQ-016 The FSM SHALL have states S_START, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE, S_GAP, S_DONE.
REQ-017 S_START SHALL count STARTUP_CYCLES clocks, then go to S_ISSUE with idx=0.
REQ-018 S_ISSUE SHALL wait for i2c_idle=1, then drive wr_i2c=1 for exactly one cycle and go to S_WAIT_BUSY.
REQ-019 din SHALL be valid in the wr_i2c cycle and held stable until the write completes (S_WAIT_IDLE exit); the engine latches din combinationally while idle.
REQ-020 S_WAIT_BUSY SHALL go to S_WAIT_IDLE when i2c_idle=0.
REQ-021 If i2c_idle does not fall within 4 cycles of the strobe, the write SHALL be treated as complete.
REQ-022 S_WAIT_IDLE SHALL go to S_GAP when i2c_idle=1.
REQ-023 If S_WAIT_IDLE lasts TIMEOUT_CYCLES, the FSM SHALL set err=1 and go to S_DONE.
REQ-024 S_GAP SHALL count GAP_CYCLES clocks; then go to S_ISSUE with idx+1 if idx<10, else go to S_DONE; idx SHALL never wrap.
REQ-025 S_DONE SHALL hold done=1, busy=0, wr_i2c=0.
REQ-026 start in S_DONE SHALL clear done and err, set idx=0, and go to S_ISSUE with no startup delay.
REQ-027 start in any other state SHALL be ignored.
REQ-028 busy SHALL be 1 in every state except S_DONE.
REQ-029 wr_i2c SHALL never be asserted on two consecutive cycles.

Reset
REQ-030 While reset=1: state=S_START, counters=0, idx=0, wr_i2c=0, din=0, busy=1, done=0, err=0.
REQ-031 Reset asserted mid-write SHALL abort the sequence and restart the startup delay; the table is replayed in full.

Configuration
REQ-032 Macro CODEC_CFG_USER_EN SHALL add ports usr_req (in, 1), usr_addr (in, 7), usr_data (in, 9), usr_ack (out, 1).
REQ-033 With CODEC_CFG_USER_EN defined, usr_req=1 in S_DONE SHALL issue one write {DEV_ADDR, usr_addr, usr_data} via S_ISSUE/S_WAIT_BUSY/S_WAIT_IDLE.
REQ-034 After that write completes, usr_ack SHALL pulse 1 cycle and the FSM SHALL return to S_DONE without running S_GAP.
REQ-035 usr_req SHALL stay pending during init or a user write and be served on the next entry to S_DONE.
REQ-036 If start and usr_req are both high in S_DONE, start SHALL take priority.
REQ-037 Without CODEC_CFG_USER_EN, the user ports SHALL be absent and behaviour SHALL be as REQ-015..031 only.

Verification
REQ-038 STARTUP_CYCLES=8, GAP_CYCLES=2, engine model idle-low for 20 cycles per write -> first wr_i2c at cycle 9 after reset release with din=24'h341E00; 11 strobes; last din=24'h341201; done=1.
REQ-039 Engine model holds i2c_idle=0 on write 3, TIMEOUT_CYCLES=50 -> err=1 and done=1 fifty cycles after entering S_WAIT_IDLE; idx=3; no further strobes.
REQ-040 Pulse start after done -> done=0, err=0, first strobe din=24'h341E00 within 2 cycles; start pulsed again mid-sequence -> ignored, 11 strobes total.
REQ-041 Reset asserted during write 5 -> wr_i2c=0 and idx=0 next cycle; after reset release, full replay starting from din=24'h341E00.
REQ-042 CODEC_CFG_USER_EN: usr_req with addr 7'h02 and data 9'h07F held during init -> served after done with din=24'h34047F; usr_ack single pulse; start+usr_req together -> init runs first.
